// File: rtl/aes_blk_ctrl_pkg.sv
// Shared widths and FSM state encoding for the AES block controller.
package aes_blk_ctrl_pkg;

  localparam int unsigned AES_DW    = 128;
  localparam int unsigned AES_CNT_W = 16;
  localparam int unsigned AES_TMO   = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_tmo_cnt.sv
// Wait-cycle counter for the AES core; o_exp_c flags the last allowed WAIT cycle.
module aes_tmo_cnt #(
  parameter int unsigned TMO = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_exp_c
);

  localparam int unsigned TW = (TMO > 1) ? $clog2(TMO) : 1;

  logic [TW-1:0] r_cnt;

  // Holds at the expiry value; the controller leaves WAIT on that cycle anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_exp_c) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_exp_c = (r_cnt == TW'(TMO - 1));

endmodule

// File: rtl/aes_blk_ctrl.sv
// Sequences key loads and data blocks between the input word assembler, the AES core and the output serializer.
module aes_blk_ctrl
  import aes_blk_ctrl_pkg::*;
#(
  parameter int unsigned DW    = AES_DW,
  parameter int unsigned CNT_W = AES_CNT_W,
  parameter int unsigned TMO   = AES_TMO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    in_data,
  input  logic             in_ctrl,
  input  logic             in_rdy,
  output logic             in_pull,
  output logic [DW-1:0]    key,
  output logic             key_ld,
  output logic [DW-1:0]    aes_din,
  output logic             aes_start,
  input  logic             aes_done,
  input  logic [DW-1:0]    aes_dout,
  output logic [DW-1:0]    out_data,
  output logic             out_vld,
  input  logic             out_ack,
  output logic             key_valid,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err_nokey,
  output logic             err_tmo,
  input  logic             err_clr
);

  aes_state_e r_state;
  logic       w_tmo_exp;
  logic       w_tmo_clr;
  logic       w_tmo_en;

  assign w_tmo_clr = (r_state == ST_START);
  assign w_tmo_en  = (r_state == ST_WAIT);

  aes_tmo_cnt #(
    .TMO (TMO)
  ) u_tmo_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_tmo_clr),
    .i_en    (w_tmo_en),
    .o_exp_c (w_tmo_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      in_pull   <= 1'b0;
      key       <= '0;
      key_ld    <= 1'b0;
      aes_din   <= '0;
      aes_start <= 1'b0;
      out_data  <= '0;
      out_vld   <= 1'b0;
      key_valid <= 1'b0;
      blk_cnt   <= '0;
      err_nokey <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      in_pull   <= 1'b0;
      key_ld    <= 1'b0;
      aes_start <= 1'b0;

      // Clear first so that an error raised below in the same cycle wins.
      if (err_clr) begin
        err_nokey <= 1'b0;
        err_tmo   <= 1'b0;
      end

      case (r_state)
        // in_rdy is ignored while the previous pull is still in flight.
        ST_IDLE: begin
          if (in_rdy && !in_pull) begin
            in_pull <= 1'b1;
            if (in_ctrl) begin
              key     <= in_data;
              r_state <= ST_KEY;
            end else if (key_valid) begin
              aes_din <= in_data;
              r_state <= ST_START;
            end else begin
              err_nokey <= 1'b1;
            end
          end
        end
        ST_KEY: begin
          key_ld    <= 1'b1;
          key_valid <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_START: begin
          aes_start <= 1'b1;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (aes_done) begin
            out_data <= aes_dout;
            out_vld  <= 1'b1;
            r_state  <= ST_OUT;
          end else if (w_tmo_exp) begin
            err_tmo <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_OUT: begin
          if (out_ack) begin
            out_vld <= 1'b0;
            blk_cnt <= blk_cnt + CNT_W'(1);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_blk_ctrl.sv
// Directed bench: a long-timeout instance runs a per-cycle vector table, a short-timeout/2-bit-counter instance runs corner sequences.
module tb_aes_blk_ctrl;

  localparam int unsigned DW = 128;
  localparam logic [DW-1:0] K_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] K_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] K_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] Z128  = 128'h0;
  localparam int NROW = 27;

  logic clk = 1'b0;
  logic reset, in_ctrl, in_rdy, aes_done, out_ack, err_clr;
  logic [DW-1:0] in_data, aes_dout;

  logic in_pull_a, key_ld_a, aes_start_a, out_vld_a, key_valid_a, err_nokey_a, err_tmo_a;
  logic [DW-1:0] key_a, aes_din_a, out_data_a;
  logic [15:0] blk_cnt_a;

  logic in_pull_b, key_ld_b, aes_start_b, out_vld_b, key_valid_b, err_nokey_b, err_tmo_b;
  logic [DW-1:0] key_b, aes_din_b, out_data_b;
  logic [1:0] blk_cnt_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_blk_ctrl #(.DW(DW), .CNT_W(16), .TMO(64)) u_dut_a (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_rdy(in_rdy),
    .in_pull(in_pull_a), .key(key_a), .key_ld(key_ld_a), .aes_din(aes_din_a),
    .aes_start(aes_start_a), .aes_done(aes_done), .aes_dout(aes_dout),
    .out_data(out_data_a), .out_vld(out_vld_a), .out_ack(out_ack),
    .key_valid(key_valid_a), .blk_cnt(blk_cnt_a), .err_nokey(err_nokey_a),
    .err_tmo(err_tmo_a), .err_clr(err_clr)
  );

  aes_blk_ctrl #(.DW(DW), .CNT_W(2), .TMO(8)) u_dut_b (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_rdy(in_rdy),
    .in_pull(in_pull_b), .key(key_b), .key_ld(key_ld_b), .aes_din(aes_din_b),
    .aes_start(aes_start_b), .aes_done(aes_done), .aes_dout(aes_dout),
    .out_data(out_data_b), .out_vld(out_vld_b), .out_ack(out_ack),
    .key_valid(key_valid_b), .blk_cnt(blk_cnt_b), .err_nokey(err_nokey_b),
    .err_tmo(err_tmo_b), .err_clr(err_clr)
  );

  // flags = {pull, key_ld, start, vld, key_valid, err_nokey}; bus = {key set, aes_din set, out_data set}
  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       ctl;
    logic [1:0] dsel;
    logic       done;
    logic       ack;
    logic       clr;
    logic [5:0] flags;
    logic [2:0] bus;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [NROW];

  function automatic vec_t v(input logic rst, rdy, ctl, input logic [1:0] dsel,
                             input logic done, ack, clr, input logic [5:0] fl,
                             input logic [2:0] bs, input logic [15:0] cnt);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.ctl = ctl; r.dsel = dsel;
    r.done = done; r.ack = ack; r.clr = clr;
    r.flags = fl; r.bus = bs; r.cnt = cnt;
    return r;
  endfunction

  function automatic logic [DW-1:0] sel(input logic [1:0] d);
    case (d)
      2'd1:    return K_KEY;
      2'd2:    return K_PT;
      2'd3:    return K_CT;
      default: return Z128;
    endcase
  endfunction

  function automatic logic [511:0] bvec();
    return {in_pull_b, key_ld_b, aes_start_b, out_vld_b, key_valid_b, err_nokey_b,
            err_tmo_b, blk_cnt_b, key_b, aes_din_b, out_data_b};
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic rst, rdy, ctl, input logic [1:0] dsel,
                       input logic done, ack, clr);
    reset = rst; in_rdy = rdy; in_ctrl = ctl;
    in_data = sel(dsel); aes_dout = sel(dsel);
    aes_done = done; out_ack = ack; err_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v(1,0,0,2'd0,0,0,0, 6'b000000, 3'b000, 16'd0);
    tbl[1]  = v(0,0,0,2'd0,0,0,0, 6'b000000, 3'b000, 16'd0);
    tbl[2]  = v(0,1,1,2'd1,0,0,0, 6'b100000, 3'b100, 16'd0);
    tbl[3]  = v(0,0,0,2'd0,0,0,0, 6'b010010, 3'b100, 16'd0);
    tbl[4]  = v(0,1,0,2'd2,0,0,0, 6'b100010, 3'b110, 16'd0);
    tbl[5]  = v(0,0,0,2'd0,0,0,0, 6'b001010, 3'b110, 16'd0);
    for (int i = 6; i < 15; i++)
      tbl[i] = v(0,0,0,2'd0,0,0,0, 6'b000010, 3'b110, 16'd0);
    tbl[15] = v(0,0,0,2'd3,1,0,0, 6'b000110, 3'b111, 16'd0);
    tbl[16] = v(0,0,0,2'd2,1,0,0, 6'b000110, 3'b111, 16'd0);
    tbl[17] = v(0,0,0,2'd0,0,0,0, 6'b000110, 3'b111, 16'd0);
    tbl[18] = v(0,0,0,2'd0,0,1,0, 6'b000010, 3'b111, 16'd1);
    tbl[19] = v(0,0,0,2'd0,0,1,0, 6'b000010, 3'b111, 16'd1);
    tbl[20] = v(1,0,0,2'd0,0,0,0, 6'b000000, 3'b000, 16'd0);
    tbl[21] = v(0,1,0,2'd2,0,0,0, 6'b100001, 3'b000, 16'd0);
    tbl[22] = v(0,0,0,2'd0,0,0,0, 6'b000001, 3'b000, 16'd0);
    tbl[23] = v(0,0,0,2'd0,0,0,0, 6'b000001, 3'b000, 16'd0);
    tbl[24] = v(0,0,0,2'd0,0,0,1, 6'b000000, 3'b000, 16'd0);
    tbl[25] = v(0,1,0,2'd2,0,0,1, 6'b100001, 3'b000, 16'd0);
    tbl[26] = v(0,0,0,2'd0,0,0,0, 6'b000001, 3'b000, 16'd0);

    for (int i = 0; i < NROW; i++) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].ctl, tbl[i].dsel, tbl[i].done, tbl[i].ack, tbl[i].clr);
      tick();
      chk($sformatf("row%0d_ctl", i),
          {in_pull_a, key_ld_a, aes_start_a, out_vld_a, key_valid_a, err_nokey_a, err_tmo_a, blk_cnt_a},
          {tbl[i].flags, 1'b0, tbl[i].cnt});
      chk($sformatf("row%0d_bus", i), {key_a, aes_din_a, out_data_a},
          {(tbl[i].bus[2] ? K_KEY : Z128), (tbl[i].bus[1] ? K_PT : Z128),
           (tbl[i].bus[0] ? K_CT : Z128)});
    end

    // Timeout: expiry on the 8th WAIT cycle, then done exactly on the expiry cycle
    drive(1,0,0,2'd0,0,0,0); tick();
    chk("b_reset", bvec(), 512'h0);
    drive(0,1,1,2'd1,0,0,0); tick();
    drive(0,0,0,2'd0,0,0,0); tick();
    drive(0,1,0,2'd2,0,0,0); tick();
    drive(0,0,0,2'd0,0,0,0); tick();
    chk("tmo_start", aes_start_b, 1);
    repeat (7) tick();
    chk("tmo_pre", {err_tmo_b, out_vld_b}, 2'b00);
    tick();
    chk("tmo_hit", {err_tmo_b, out_vld_b}, 2'b10);
    drive(0,1,0,2'd2,0,0,0); tick();
    chk("tmo_idle_pull", in_pull_b, 1);
    drive(0,0,0,2'd0,0,0,0); tick();
    chk("tmo_restart", aes_start_b, 1);
    drive(0,0,0,2'd0,0,0,1); tick();
    chk("tmo_clr", err_tmo_b, 0);
    drive(0,0,0,2'd0,0,0,0);
    repeat (6) tick();
    drive(0,0,0,2'd3,1,0,0); tick();
    chk("tmo_edge_done", {out_vld_b, err_tmo_b, out_data_b}, {1'b1, 1'b0, K_CT});
    drive(0,0,0,2'd0,0,1,0); tick();
    chk("tmo_edge_ack", {out_vld_b, blk_cnt_b}, {1'b0, 2'd1});

    // Counter wrap with back-pressure; upstream keeps in_rdy high during OUT
    drive(1,0,0,2'd0,0,0,0); tick();
    drive(0,1,1,2'd1,0,0,0); tick();
    drive(0,0,0,2'd0,0,0,0); tick();
    for (int b = 0; b < 5; b++) begin
      drive(0,1,0,2'd2,0,0,0); tick();
      drive(0,0,0,2'd0,0,0,0); tick();
      drive(0,0,0,2'd3,1,0,0); tick();
      chk($sformatf("wrap%0d_vld", b), {out_vld_b, out_data_b}, {1'b1, K_CT});
      drive(0,1,0,2'd2,0,0,0);
      for (int d = 0; d < b; d++) begin
        tick();
        chk($sformatf("wrap%0d_hold%0d", b, d), {in_pull_b, out_vld_b}, 2'b01);
      end
      drive(0,0,0,2'd0,0,1,0); tick();
      chk($sformatf("wrap%0d_ack", b), {in_pull_b, out_vld_b}, 2'b00);
    end
    drive(0,0,0,2'd0,0,0,0); tick();
    chk("wrap_cnt", blk_cnt_b, 2'd1);

    // Reset while waiting on the core; the late result must be dropped
    drive(0,1,0,2'd2,0,0,0); tick();
    drive(0,0,0,2'd0,0,0,0); tick();
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_async", bvec(), 512'h0);
    tick();
    drive(0,0,0,2'd3,1,0,0); tick();
    chk("rst_done_ignored", bvec(), 512'h0);
    drive(0,0,0,2'd0,0,0,0); tick();
    chk("rst_quiet", bvec(), 512'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
